mdu_hilo_unit: RTL



---
 rtl/mdu_hilo_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mdu_hilo_unit.sv
// rtl/mdu_hilo_unit.sv - iterative multiply/divide unit owning HI/LO
// Optional div-by-zero flag output enabled by `define MDU_DIV0_FLAG_EN
module mdu_hilo_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
`ifdef MDU_DIV0_FLAG_EN
    output logic            div0,
`endif
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);
    localparam int CW = $clog2(XLEN);

    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MFHI  = 5'b10011;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;

    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            accept;

    logic [XLEN-1:0]   addend;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    assign op_ready = !busy;
    assign hi_out   = hi;
    assign lo_out   = lo;
    assign accept   = op_valid && op_ready && !flush && (state == S_IDLE);

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign a_neg     = signed_op && a[XLEN-1];
    assign b_neg     = signed_op && b[XLEN-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Multiply: add-then-shift-right of {acc_hi, acc_lo}, multiplier consumed from acc_lo[0].
    assign addend  = acc_lo[0] ? opnd : '0;
    assign mul_sum = {1'b0, acc_hi} + {1'b0, addend};

    // Divide: restoring step, dividend bits shifted out of acc_lo into the remainder.
    assign rem_shift = {acc_hi, acc_lo[XLEN-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd};

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -acc_lo : acc_lo;
    // With a zero divisor the remainder ends as |a|, so restoring the dividend sign yields a.
    assign rem_fix  = neg_r ? -acc_hi : acc_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
`ifdef MDU_DIV0_FLAG_EN
            div0     <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                acc_hi   <= '0;
                                acc_lo   <= b_mag;
                                opnd     <= a_mag;
                                is_div   <= 1'b0;
                                neg_q    <= a_neg ^ b_neg;
                                neg_r    <= 1'b0;
                                div_zero <= 1'b0;
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= S_CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_hi   <= '0;
                                acc_lo   <= a_mag;
                                opnd     <= b_mag;
                                is_div   <= 1'b1;
                                neg_q    <= a_neg ^ b_neg;
                                neg_r    <= a_neg;
                                div_zero <= (b == '0);
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= S_CALC;
                            end
                            OP_MFHI: begin
                                rd_data  <= hi;
                                rd_valid <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data  <= lo;
                                rd_valid <= 1'b1;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        if (is_div) begin
                            acc_hi <= rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
                            acc_lo <= {acc_lo[XLEN-2:0], !rem_diff[XLEN]};
                        end else begin
                            acc_hi <= mul_sum[XLEN:1];
                            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                        end
                        if (cnt == CW'(XLEN - 1)) begin
                            cnt   <= '0;
                            state <= S_FIX;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= div_zero ? '1 : quot_fix;
`ifdef MDU_DIV0_FLAG_EN
                            div0 <= div_zero;
`endif
                        end else begin
                            hi <= prod_fix[2*XLEN-1:XLEN];
                            lo <= prod_fix[XLEN-1:0];
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
